// File: rtl/qpsk_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_frame_tx
// Function : Frames a 24-bit payload as {HEADER, payload, checksum} and sends
//            it MSB first as 20 QPSK symbols (I bit, then Q bit), each held
//            for SAMPLE clocks, followed by GAP idle symbols.
// Revision : 1.0 - initial release
// ============================================================================
module qpsk_frame_tx #(
  parameter logic [7:0] HEADER = 8'hcc,
  parameter int         SAMPLE = 100,   // clocks per symbol, 2..1023
  parameter int         GAP    = 4      // idle symbols after a frame, 0..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        i_bit,
  output logic        q_bit,
  output logic        sym_strobe,
  output logic        tx_active,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [9:0]  C_SAMPLE_LAST = 10'(SAMPLE - 1);
  localparam logic [4:0]  C_SYM_LAST    = 5'd19;
  // Idle period is timed as one flat count of GAP*SAMPLE clocks.
  localparam logic [13:0] C_GAP_LAST    = 14'(GAP * SAMPLE - 1);

  state_t      r_state;
  logic [39:0] r_shift;
  logic [9:0]  r_sample_cnt;
  logic [4:0]  r_sym_cnt;
  logic [13:0] r_gap_cnt;

  logic [7:0]  w_csum;
  logic [39:0] w_frame;

  // Byte-sum checksum, accumulated at 10 bits and truncated to the low byte.
  function automatic logic [7:0] csum8(input logic [23:0] d);
    logic [9:0] s;
    s = 10'(d[23:16]) + 10'(d[15:8]) + 10'(d[7:0]);
    return s[7:0];
  endfunction

  assign w_csum  = csum8(data_in);
  assign w_frame = {HEADER, data_in, w_csum};

  // Framer FSM: captures payload, serialises symbols, times the idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_sample_cnt <= '0;
      r_sym_cnt    <= '0;
      r_gap_cnt    <= '0;
      data_ready   <= 1'b0;
      i_bit        <= 1'b0;
      q_bit        <= 1'b0;
      sym_strobe   <= 1'b0;
      tx_active    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_valid && data_ready) begin
            // Symbol 0 goes out straight from the freshly built frame.
            r_shift      <= w_frame;
            i_bit        <= w_frame[39];
            q_bit        <= w_frame[38];
            tx_active    <= 1'b1;
            sym_strobe   <= 1'b1;
            data_ready   <= 1'b0;
            r_sample_cnt <= '0;
            r_sym_cnt    <= '0;
            r_state      <= S_SEND;
          end else begin
            data_ready <= 1'b1;
          end
        end

        S_SEND: begin
          if (r_sample_cnt == C_SAMPLE_LAST) begin
            r_sample_cnt <= '0;
            if (r_sym_cnt == C_SYM_LAST) begin
              frame_done <= 1'b1;
              tx_active  <= 1'b0;
              i_bit      <= 1'b0;
              q_bit      <= 1'b0;
              r_sym_cnt  <= '0;
              r_gap_cnt  <= '0;
              if (GAP > 0) begin
                r_state <= S_GAP;
              end else begin
                r_state    <= S_IDLE;
                data_ready <= 1'b1;
              end
            end else begin
              // Next symbol sits just below the pair currently on air.
              r_sym_cnt  <= r_sym_cnt + 5'd1;
              r_shift    <= {r_shift[37:0], 2'b00};
              i_bit      <= r_shift[37];
              q_bit      <= r_shift[36];
              sym_strobe <= 1'b1;
            end
          end else begin
            r_sample_cnt <= r_sample_cnt + 10'd1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == C_GAP_LAST) begin
            r_gap_cnt  <= '0;
            data_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 14'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpsk_frame_tx
// Function : Directed bench for qpsk_frame_tx with SAMPLE=4. One instance
//            runs GAP=0 (frame table, reset cases), a second runs GAP=4
//            (back-to-back payloads with data_valid held high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpsk_frame_tx;

  localparam int SMP = 4;

  typedef struct {
    logic [23:0] d;
    logic [39:0] f;
    bit          tog;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] tb_data;
  logic        dv;
  logic        sel;       // 0: GAP=0 instance, 1: GAP=4 instance

  logic dv0, dr0, i0, q0, st0, tx0, fd0;
  logic dv4, dr4, i4, q4, st4, tx4, fd4;
  logic m_ready, m_i, m_q, m_strobe, m_tx, m_done;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          acc_cyc;
  logic [39:0] last_cap;
  int          acc[3];
  vec_t        vt[6];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dv0      = dv & ~sel;
  assign dv4      = dv &  sel;
  assign m_ready  = sel ? dr4 : dr0;
  assign m_i      = sel ? i4  : i0;
  assign m_q      = sel ? q4  : q0;
  assign m_strobe = sel ? st4 : st0;
  assign m_tx     = sel ? tx4 : tx0;
  assign m_done   = sel ? fd4 : fd0;

  qpsk_frame_tx #(.HEADER(8'hcc), .SAMPLE(SMP), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(tb_data), .data_valid(dv0),
    .data_ready(dr0), .i_bit(i0), .q_bit(q0), .sym_strobe(st0),
    .tx_active(tx0), .frame_done(fd0)
  );

  qpsk_frame_tx #(.HEADER(8'hcc), .SAMPLE(SMP), .GAP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(tb_data), .data_valid(dv4),
    .data_ready(dr4), .i_bit(i4), .q_bit(q4), .sym_strobe(st4),
    .tx_active(tx4), .frame_done(fd4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Sends one payload on the selected instance and checks every cycle of
  // the frame plus the done/gap cycles that follow it.
  task automatic run_frame(input logic [23:0] d, input logic [39:0] exp,
                           input bit tog, input int gap, input bit hold,
                           input string nm);
    int n, k, bad_bits, bad_strb, bad_ctl, idle;
    logic [39:0] cap;
    n = 0;
    @(negedge clk);
    while (m_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 64'(m_ready), 64'd1);
    acc_cyc = cyc;
    tb_data = d;
    dv      = 1'b1;
    @(posedge clk);
    bad_bits = 0; bad_strb = 0; bad_ctl = 0; cap = '0;
    for (int c = 1; c <= 20 * SMP; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) dv = 1'b0;
      if (tog) tb_data = 24'($urandom);
      k = (c - 1) / SMP;
      if (m_i !== exp[39 - 2*k] || m_q !== exp[38 - 2*k]) bad_bits++;
      if (m_strobe !== (((c - 1) % SMP) == 0)) bad_strb++;
      if (m_tx !== 1'b1 || m_done !== 1'b0 || m_ready !== 1'b0) bad_ctl++;
      if (m_strobe === 1'b1) cap = {cap[37:0], m_i, m_q};
    end
    last_cap = cap;
    chk({nm, " frame"}, 64'(cap), 64'(exp));
    chk({nm, " bits"}, 64'(bad_bits), 64'd0);
    chk({nm, " strobe"}, 64'(bad_strb), 64'd0);
    chk({nm, " ctl"}, 64'(bad_ctl), 64'd0);
    @(negedge clk);
    chk({nm, " done"}, 64'({m_done, m_tx, m_i, m_q, m_strobe}), 64'(5'b10000));
    chk({nm, " ready@done"}, 64'(m_ready), 64'(gap == 0));
    if (gap > 0) begin
      idle = 1;
      for (int j = 1; j < gap * SMP; j++) begin
        @(negedge clk);
        if (j == gap * SMP - 1 && hold == 1'b0) dv = 1'b0;
        if ({m_done, m_tx, m_i, m_q, m_strobe, m_ready} === 6'b0) idle++;
      end
      chk({nm, " idle"}, 64'(idle), 64'(gap * SMP));
    end else begin
      @(negedge clk);
      chk({nm, " done low"}, 64'(m_done), 64'd0);
    end
  endtask

  initial begin
    vt[0] = '{24'h123456, 40'hCC1234569C, 1'b0, "v123456"};
    vt[1] = '{24'hFFFFFF, 40'hCCFFFFFFFD, 1'b0, "vFFFFFF"};
    vt[2] = '{24'h000000, 40'hCC00000000, 1'b0, "v000000"};
    vt[3] = '{24'hABCDEF, 40'hCCABCDEF67, 1'b0, "vABCDEF"};
    vt[4] = '{24'h808080, 40'hCC80808080, 1'b0, "v808080"};
    vt[5] = '{24'hA5C3E1, 40'hCCA5C3E149, 1'b1, "vtoggle"};

    sel = 1'b0; dv = 1'b0; tb_data = '0; rst_n = 1'b0;

    // Reset state and release.
    #1;
    chk("rst outs", 64'({dr0, i0, q0, st0, tx0, fd0}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst held", 64'({dr0, i0, q0, st0, tx0, fd0}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready pre-edge", 64'(dr0), 64'd0);
    @(negedge clk);
    chk("ready 1st edge", 64'(dr0), 64'd1);
    begin
      int bad;
      bad = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if ({i0, q0, st0, tx0, fd0} !== 5'b0 || dr0 !== 1'b1) bad++;
      end
      chk("idle quiet", 64'(bad), 64'd0);
    end

    // Frame table on the GAP=0 instance.
    for (int v = 0; v < 6; v++) begin
      run_frame(vt[v].d, vt[v].f, vt[v].tog, 0, 1'b0, vt[v].nm);
      if (v == 1) chk("FFFFFF tail", 64'(last_cap[7:0]), 64'h00FD);
    end

    // Reset asserted during symbol 7, asynchronously between edges.
    begin
      int n;
      n = 0;
      while (dr0 !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      tb_data = 24'h0F0F0F;
      dv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      repeat (29) @(negedge clk);
      chk("mid tx", 64'(tx0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst async", 64'({dr0, i0, q0, st0, tx0, fd0}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(24'h123456, 40'hCC1234569C, 1'b0, 0, 1'b0, "post rst");
    end

    // GAP=4 instance with data_valid held high back to back.
    sel = 1'b1;
    run_frame(24'h123456, 40'hCC1234569C, 1'b0, 4, 1'b1, "g0");
    acc[0] = acc_cyc;
    run_frame(24'hFFFFFF, 40'hCCFFFFFFFD, 1'b0, 4, 1'b1, "g1");
    acc[1] = acc_cyc;
    run_frame(24'hABCDEF, 40'hCCABCDEF67, 1'b0, 4, 1'b1, "g2");
    acc[2] = acc_cyc;
    dv = 1'b0;
    chk("period 0-1", 64'(acc[1] - acc[0]), 64'd97);
    chk("period 1-2", 64'(acc[2] - acc[1]), 64'd97);
    repeat (3) @(negedge clk);
    chk("g no extra", 64'({tx4, st4}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
